// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 4-digit BCD display scanner
// Time-sliced digit scan with dead time, frame-synchronous digit updates and leading-zero blanking.
module display_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        blank,
  input  logic        lz_en,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int CMAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic          wrap;

  logic [15:0]   staging;
  logic [15:0]   shadow, shadow_nxt;
  logic          pending, pending_nxt;

  logic [3:0]    digit_sel;
  logic          suppress;
  logic [3:0]    bcd_nxt;
  logic [3:0]    en_nxt;
  logic          fd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_DEAD;
      cnt   <= '0;
      ptr   <= 2'd3;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // The pointer only moves on DEAD->SHOW, so that edge is the sole place a 3->0 wrap can occur.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    ptr_nxt   = ptr;
    wrap      = 1'b0;
    unique case (state)
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = '0;
        end
      end
      ST_DEAD: begin
        if (cnt == DEAD_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
          ptr_nxt   = ptr + 2'd1;
          wrap      = (ptr == 2'd3);
        end
      end
    endcase
  end

  // A load on the wrap edge still hands the older staged value to the shadow and stays pending.
  always_comb begin
    shadow_nxt  = shadow;
    pending_nxt = pending;
    if (wrap) begin
      if (pending) begin
        shadow_nxt = staging;
      end
      pending_nxt = 1'b0;
    end
    if (load) begin
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
    end else begin
      if (load) begin
        staging <= digits_in;
      end
      shadow  <= shadow_nxt;
      pending <= pending_nxt;
    end
  end

  // Outputs are decoded from the post-edge state so the registered pins line up with the FSM cycle.
  always_comb begin
    en_nxt    = 4'b0000;
    bcd_nxt   = 4'b1111;
    fd_nxt    = wrap;
    digit_sel = shadow_nxt[{ptr_nxt, 2'b00} +: 4];
    suppress  = 1'b0;
    if (lz_en) begin
      unique case (ptr_nxt)
        2'd3:    suppress = (shadow_nxt[15:12] == 4'h0);
        2'd2:    suppress = (shadow_nxt[15:8] == 8'h00);
        2'd1:    suppress = (shadow_nxt[15:4] == 12'h000);
        default: suppress = 1'b0;
      endcase
    end
    if (state_nxt == ST_SHOW && !blank) begin
      en_nxt  = 4'b0001 << ptr_nxt;
      bcd_nxt = suppress ? 4'b1111 : digit_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en   <= 4'b0000;
      bcd_out    <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      digit_en   <= en_nxt;
      bcd_out    <= bcd_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule
